data_memory_ws: RTL

Parametrised data memory with programmable wait states, a request/ready handshake, sub-word load/store handling and access statistics. It replaces the zero-latency data memory on the CPU data bus, so that the core and the simulation harness can exercise stall behaviour against slow memory. It also reports misaligned and out-of-range accesses instead of silently aliasing them.

---
 rtl/data_memory_ws.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/data_memory_ws.sv
// Data memory with programmable load/store wait states, a req/ready handshake,
// sub-word little-endian access, fault reporting and access statistics.
module data_memory_ws #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = 32,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output logic [31:0]       stall_count
);

  localparam int NBYTES = DATA_W / 8;
  localparam int OFF_W  = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LOC_W  = OFF_W + IDX_W;
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(DEPTH * NBYTES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [LOC_W-1:0]  loc_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              misaligned;
  logic              out_of_range;
  logic              bad_size;
  logic              req_err;
  logic              do_access;
  logic              do_store;
  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  off;
  logic [DATA_W-1:0] cur_word;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] wdata_sh;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] load_val;
  logic [NBYTES-1:0] base_mask;
  logic [NBYTES-1:0] lane_mask;

  // Request fault checks are evaluated on the live inputs at acceptance.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'd1:    misaligned = addr[0];
      2'd2:    misaligned = |addr[1:0];
      2'd3:    misaligned = |addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign out_of_range = {1'b0, addr} >= MEM_BYTES;
  assign bad_size     = (size == 2'd3) && (DATA_W == 32);
  assign req_err      = misaligned || out_of_range || bad_size;

  assign idx       = loc_q[OFF_W +: IDX_W];
  assign off       = loc_q[OFF_W-1:0];
  assign do_access = (state == WAIT) && (cnt == 4'd0);
  assign do_store  = do_access && we_q;
  assign cur_word  = mem[idx];
  assign shifted   = cur_word >> {off, 3'b000};
  assign wdata_sh  = wdata_q << {off, 3'b000};

  always_comb begin
    base_mask = '0;
    case (size_q)
      2'd0:    base_mask = NBYTES'(1'b1);
      2'd1:    base_mask = NBYTES'(2'b11);
      2'd2:    base_mask = NBYTES'(4'b1111);
      default: base_mask = '1;
    endcase
    lane_mask = base_mask << off;
  end

  always_comb begin
    wr_word = cur_word;
    for (int i = 0; i < NBYTES; i++) begin
      if (lane_mask[i]) wr_word[i*8 +: 8] = wdata_sh[i*8 +: 8];
    end
  end

  // Loaded lanes sit at the bottom of 'shifted'; extend them to the full word.
  always_comb begin
    load_val = shifted;
    case (size_q)
      2'd0: load_val = uns_q ? DATA_W'(shifted[7:0])  : DATA_W'($signed(shifted[7:0]));
      2'd1: load_val = uns_q ? DATA_W'(shifted[15:0]) : DATA_W'($signed(shifted[15:0]));
      2'd2: load_val = uns_q ? DATA_W'(shifted[31:0]) : DATA_W'($signed(shifted[31:0]));
      default: load_val = shifted;
    endcase
  end

  // The array has no reset; an aborted store never reaches this write port.
  always_ff @(posedge clock) begin
    if (do_store) mem[idx] <= wr_word;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      loc_q       <= '0;
      wdata_q     <= '0;
      rdata       <= '0;
      ready       <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
      rd_count    <= 32'd0;
      wr_count    <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      ready <= 1'b0;
      if (busy) stall_count <= stall_count + 32'd1;
      case (state)
        IDLE, RESP: begin
          if (req) begin
            we_q    <= we;
            size_q  <= size;
            uns_q   <= unsigned_ld;
            loc_q   <= addr[LOC_W-1:0];
            wdata_q <= wdata;
            if (req_err) begin
              state <= RESP;
              ready <= 1'b1;
              err   <= 1'b1;
              rdata <= '0;
              busy  <= 1'b0;
            end else begin
              state <= WAIT;
              cnt   <= we ? 4'(WRITE_LAT) : 4'(READ_LAT);
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
            ready <= 1'b1;
            err   <= 1'b0;
            busy  <= 1'b0;
            if (we_q) begin
              wr_count <= wr_count + 32'd1;
            end else begin
              rd_count <= rd_count + 32'd1;
              rdata    <= load_val;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
